priority_resolver_rotating: RTL and testbench

- Parametrised, registered successor to the PIC 8259 priority resolver.
- Picks the highest-priority pending, unmasked, non-blocked request among N_IRQ lines, using a rotatable priority ring.
- Decodes End-Of-Interrupt (EOI) commands into a one-hot ISR-clear pulse and rotates priority on command.
- Sits between the IRR/IMR/ISR registers and the control logic (INT/INTA sequencer).

---
 rtl/priority_resolver_rotating.sv | 114 +++++++++++
 tb/tb_priority_resolver_rotating.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_rotating.sv
`default_nettype none
// ============================================================================
// Module   : priority_resolver_rotating
// Purpose  : Rotating-priority interrupt resolver with EOI decode (8259-style).
// Revision : 1.0
// ============================================================================
module priority_resolver_rotating #(
  parameter  int N_IRQ = 8,
  localparam int IDW   = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irr,
  input  logic [N_IRQ-1:0] imr,
  input  logic [N_IRQ-1:0] isr,
  input  logic             special_mask_mode,
  input  logic             auto_rotate,
  input  logic             eoi_valid,
  input  logic             eoi_specific,
  input  logic             eoi_rotate,
  input  logic [IDW-1:0]   eoi_level,
  input  logic             set_prio_valid,
  input  logic [IDW-1:0]   set_prio_level,
  output logic             int_req,
  output logic [IDW-1:0]   int_id,
  output logic [N_IRQ-1:0] eoi_clear,
  output logic [IDW-1:0]   lowest_prio
);

  localparam logic [IDW-1:0] c_reset_lowest = IDW'(N_IRQ - 1);

  logic [IDW-1:0]   r_lowest;
  logic             r_int_req;
  logic [IDW-1:0]   r_int_id;
  logic [N_IRQ-1:0] r_eoi_clear;

  logic [N_IRQ-1:0] w_cand;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic             w_isr_found;
  logic [IDW-1:0]   w_top_isr;
  logic             w_blocked;
  logic [IDW-1:0]   w_pos_idx;
  int               w_pos;

  logic             w_eoi_do;
  logic             w_eoi_rot;
  logic [IDW-1:0]   w_target;
  logic [N_IRQ-1:0] w_onehot;
  logic             w_set_ok;

  assign w_cand = irr & ~imr;

  // Walk the ring from rank 0 upward. A line with its own ISR bit set is never
  // eligible; in normal mode the first in-service line also blocks all lower ranks.
  always_comb begin
    w_found     = 1'b0;
    w_win       = '0;
    w_isr_found = 1'b0;
    w_top_isr   = '0;
    w_blocked   = 1'b0;
    w_pos       = 0;
    w_pos_idx   = '0;
    for (int r = 0; r < N_IRQ; r++) begin
      w_pos = int'(r_lowest) + 1 + r;
      if (w_pos >= N_IRQ) w_pos = w_pos - N_IRQ;
      w_pos_idx = w_pos[IDW-1:0];
      if (!w_found && !w_blocked && w_cand[w_pos_idx] && !isr[w_pos_idx]) begin
        w_found = 1'b1;
        w_win   = w_pos_idx;
      end
      if (isr[w_pos_idx] && !w_isr_found) begin
        w_isr_found = 1'b1;
        w_top_isr   = w_pos_idx;
      end
      if (isr[w_pos_idx] && !special_mask_mode) w_blocked = 1'b1;
    end
  end

  always_comb begin
    w_target  = eoi_specific ? eoi_level : w_top_isr;
    w_eoi_do  = 1'b0;
    if (eoi_valid) begin
      if (eoi_specific) w_eoi_do = (int'(eoi_level) < N_IRQ);
      else              w_eoi_do = w_isr_found;
    end
    w_eoi_rot = w_eoi_do && (eoi_rotate || (auto_rotate && !eoi_specific));
    w_onehot  = {{(N_IRQ-1){1'b0}}, 1'b1} << w_target;
    w_set_ok  = set_prio_valid && (int'(set_prio_level) < N_IRQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lowest    <= c_reset_lowest;
      r_int_req   <= 1'b0;
      r_int_id    <= '0;
      r_eoi_clear <= '0;
    end else begin
      r_int_req   <= w_found;
      if (w_found) r_int_id <= w_win;
      r_eoi_clear <= w_eoi_do ? w_onehot : '0;
      // Set-priority takes precedence over an EOI rotation in the same cycle.
      if (w_set_ok)       r_lowest <= set_prio_level;
      else if (w_eoi_rot) r_lowest <= w_target;
    end
  end

  assign int_req     = r_int_req;
  assign int_id      = r_int_id;
  assign eoi_clear   = r_eoi_clear;
  assign lowest_prio = r_lowest;

endmodule
`default_nettype wire

// File: tb/tb_priority_resolver_rotating.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_resolver_rotating
// Purpose  : Directed self-checking bench for N_IRQ=8 and N_IRQ=6 instances.
// Revision : 1.0
// ============================================================================
module tb_priority_resolver_rotating;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N_IRQ = 8 instance
  logic       rst_n, smm, arot, ev, es, er, sv;
  logic [7:0] irr, imr, isr;
  logic [2:0] el, sl;
  logic       int_req;
  logic [2:0] int_id, lowest;
  logic [7:0] eclr;

  priority_resolver_rotating #(.N_IRQ(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .isr(isr),
    .special_mask_mode(smm), .auto_rotate(arot), .eoi_valid(ev),
    .eoi_specific(es), .eoi_rotate(er), .eoi_level(el),
    .set_prio_valid(sv), .set_prio_level(sl),
    .int_req(int_req), .int_id(int_id), .eoi_clear(eclr), .lowest_prio(lowest)
  );

  // N_IRQ = 6 instance
  logic       rst6_n, smm6, arot6, ev6, es6, er6, sv6;
  logic [5:0] irr6, imr6, isr6;
  logic [2:0] el6, sl6;
  logic       int_req6;
  logic [2:0] int_id6, lowest6;
  logic [5:0] eclr6;

  priority_resolver_rotating #(.N_IRQ(6)) u_dut6 (
    .clk(clk), .rst_n(rst6_n), .irr(irr6), .imr(imr6), .isr(isr6),
    .special_mask_mode(smm6), .auto_rotate(arot6), .eoi_valid(ev6),
    .eoi_specific(es6), .eoi_rotate(er6), .eoi_level(el6),
    .set_prio_valid(sv6), .set_prio_level(sl6),
    .int_req(int_req6), .int_id(int_id6), .eoi_clear(eclr6), .lowest_prio(lowest6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst6_n = 1'b0;
    irr = '0; imr = '0; isr = '0; smm = 0; arot = 0; ev = 0; es = 0; er = 0; el = '0; sv = 0; sl = '0;
    irr6 = '0; imr6 = '0; isr6 = '0; smm6 = 0; arot6 = 0; ev6 = 0; es6 = 0; er6 = 0; el6 = '0; sv6 = 0; sl6 = '0;
    tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rst_int_req got %0b want 0", int_req); end
    checks++; if (int_id !== 3'd0) begin errors++; $display("FAIL rst_int_id got %0d want 0", int_id); end
    checks++; if (eclr !== 8'h00) begin errors++; $display("FAIL rst_eoi_clear got %h want 00", eclr); end
    checks++; if (lowest !== 3'd7) begin errors++; $display("FAIL rst_lowest got %0d want 7", lowest); end
    checks++; if (lowest6 !== 3'd5) begin errors++; $display("FAIL rst6_lowest got %0d want 5", lowest6); end
    rst_n = 1'b1; rst6_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_arb();
    irr = 8'b1010_0100;
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL basic_req got %0b want 1", int_req); end
    checks++; if (int_id !== 3'd2) begin errors++; $display("FAIL basic_id got %0d want 2", int_id); end
    checks++; if (lowest !== 3'd7) begin errors++; $display("FAIL basic_lowest got %0d want 7", lowest); end
  endtask

  task automatic test_blocking();
    isr = 8'b0000_0100; irr = 8'b0000_1010;
    tick();
    checks++; if (int_id !== 3'd1) begin errors++; $display("FAIL nested_id got %0d want 1", int_id); end
    irr = 8'b0000_1000;
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL nested_blocked_req got %0b want 0", int_req); end
    checks++; if (int_id !== 3'd1) begin errors++; $display("FAIL nested_hold_id got %0d want 1", int_id); end
    smm = 1'b1; irr = 8'b0000_1010;
    tick();
    checks++; if (int_id !== 3'd1) begin errors++; $display("FAIL smm_id got %0d want 1", int_id); end
    irr = 8'b0000_1000;
    tick();
    checks++; if (int_id !== 3'd3) begin errors++; $display("FAIL smm_id3 got %0d want 3", int_id); end
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL smm_req got %0b want 1", int_req); end
    smm = 1'b0; irr = '0; isr = '0;
    tick();
  endtask

  task automatic test_auto_rotate();
    arot = 1'b1; isr = 8'b0001_0000;
    ev = 1'b1; es = 1'b0; er = 1'b0;
    tick();
    ev = 1'b0;
    checks++; if (eclr !== 8'h10) begin errors++; $display("FAIL arot_clear got %h want 10", eclr); end
    checks++; if (lowest !== 3'd4) begin errors++; $display("FAIL arot_lowest got %0d want 4", lowest); end
    isr = '0; irr = 8'b0010_0001;
    tick();
    checks++; if (eclr !== 8'h00) begin errors++; $display("FAIL arot_pulse_width got %h want 00", eclr); end
    checks++; if (int_id !== 3'd5) begin errors++; $display("FAIL arot_id got %0d want 5", int_id); end
    arot = 1'b0; irr = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    sv = 1'b1; sl = 3'd2;
    ev = 1'b1; es = 1'b1; er = 1'b1; el = 3'd6; isr = '0;
    tick();
    sv = 1'b0; ev = 1'b0; er = 1'b0;
    checks++; if (lowest !== 3'd2) begin errors++; $display("FAIL setprio_wins got %0d want 2", lowest); end
    checks++; if (eclr !== 8'h40) begin errors++; $display("FAIL setprio_eoi_clear got %h want 40", eclr); end
    irr = 8'hFF;
    tick();
    checks++; if (int_id !== 3'd3) begin errors++; $display("FAIL setprio_id got %0d want 3", int_id); end
    // Specific EOI without rotation leaves L alone.
    ev = 1'b1; es = 1'b1; er = 1'b0; el = 3'd1;
    tick();
    ev = 1'b0;
    checks++; if (eclr !== 8'h02) begin errors++; $display("FAIL spec_eoi_clear got %h want 02", eclr); end
    checks++; if (lowest !== 3'd2) begin errors++; $display("FAIL spec_eoi_lowest got %0d want 2", lowest); end
    irr = '0;
    tick();
  endtask

  task automatic test_noop_eoi();
    arot = 1'b1; isr = '0;
    ev = 1'b1; es = 1'b0; er = 1'b1;
    tick();
    ev = 1'b0; er = 1'b0; arot = 1'b0;
    checks++; if (eclr !== 8'h00) begin errors++; $display("FAIL noop_ns_clear got %h want 00", eclr); end
    checks++; if (lowest !== 3'd2) begin errors++; $display("FAIL noop_ns_lowest got %0d want 2", lowest); end
    ev6 = 1'b1; es6 = 1'b1; er6 = 1'b1; el6 = 3'd7;
    sv6 = 1'b0;
    tick();
    ev6 = 1'b0; er6 = 1'b0;
    checks++; if (eclr6 !== 6'h00) begin errors++; $display("FAIL noop_range_clear got %h want 00", eclr6); end
    checks++; if (lowest6 !== 3'd5) begin errors++; $display("FAIL noop_range_lowest got %0d want 5", lowest6); end
    sv6 = 1'b1; sl6 = 3'd6;
    tick();
    sv6 = 1'b0;
    checks++; if (lowest6 !== 3'd5) begin errors++; $display("FAIL setprio_range got %0d want 5", lowest6); end
  endtask

  task automatic test_wrap6();
    sv6 = 1'b1; sl6 = 3'd5; irr6 = 6'b10_0001;
    tick();
    sv6 = 1'b0;
    tick();
    checks++; if (int_id6 !== 3'd0) begin errors++; $display("FAIL wrap_id0 got %0d want 0", int_id6); end
    sv6 = 1'b1; sl6 = 3'd0;
    tick();
    sv6 = 1'b0;
    checks++; if (lowest6 !== 3'd0) begin errors++; $display("FAIL wrap_lowest got %0d want 0", lowest6); end
    checks++; if (int_id6 !== 3'd0) begin errors++; $display("FAIL wrap_latency got %0d want 0", int_id6); end
    tick();
    checks++; if (int_id6 !== 3'd5) begin errors++; $display("FAIL wrap_id5 got %0d want 5", int_id6); end
  endtask

  task automatic test_reset_mid_eoi();
    irr6 = '0; isr6 = 6'b00_0100; arot6 = 1'b1;
    ev6 = 1'b1; es6 = 1'b0; er6 = 1'b0;
    tick();
    ev6 = 1'b0;
    checks++; if (eclr6 !== 6'h04) begin errors++; $display("FAIL mid_pulse got %h want 04", eclr6); end
    checks++; if (lowest6 !== 3'd2) begin errors++; $display("FAIL mid_lowest got %0d want 2", lowest6); end
    #1 rst6_n = 1'b0;
    #1;
    checks++; if (eclr6 !== 6'h00) begin errors++; $display("FAIL mid_rst_clear got %h want 00", eclr6); end
    checks++; if (lowest6 !== 3'd5) begin errors++; $display("FAIL mid_rst_lowest got %0d want 5", lowest6); end
    isr6 = '0; arot6 = 1'b0;
    tick();
    rst6_n = 1'b1;
    tick();
    checks++; if (eclr6 !== 6'h00) begin errors++; $display("FAIL post_rst_clear got %h want 00", eclr6); end
    checks++; if (lowest6 !== 3'd5) begin errors++; $display("FAIL post_rst_lowest got %0d want 5", lowest6); end
  endtask

  initial begin
    test_reset();
    test_basic_arb();
    test_blocking();
    test_auto_rotate();
    test_back_to_back();
    test_noop_eoi();
    test_wrap6();
    test_reset_mid_eoi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
